// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants and arbiter helpers for rf_wb_arbiter.
// Build option: RF_WB_RR_EN selects round-robin instead of fixed priority.
package rf_wb_arbiter_pkg;

  localparam int RF_AW = 4;
  localparam int RF_DW = 32;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus, rf16 write port and hazard lines.
// Build option: RF_WB_RR_EN (arbitration policy, no effect on this bundle).
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic               rf_busy;
  logic [AW-1:0]      r0addr;
  logic [AW-1:0]      r1addr;
  logic               rf_wea;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               r0_hazard;
  logic               r1_hazard;

  modport master (
    output req_valid, req_waddr, req_wdata,
    output rf_busy, r0addr, r1addr,
    input  req_ready, rf_wea, rf_waddr, rf_wdata,
    input  r0_hazard, r1_hazard
  );

  modport slave (
    input  req_valid, req_waddr, req_wdata,
    input  rf_busy, r0addr, r1addr,
    output req_ready, rf_wea, rf_waddr, rf_wdata,
    output r0_hazard, r1_hazard
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant from a request vector, gated by an enable.
// RF_WB_RR_EN defined: round-robin with pointer; else fixed lowest-index priority.
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt
);

`ifdef RF_WB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;

  always_comb begin : search
    int   j;
    logic found;
    o_gnt = '0;
    w_nxt = r_ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && i_en && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        w_nxt    = PW'(wrap_inc(j, NREQ));
      end
    end
  end

  // Pointer only moves on an actual grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (|o_gnt)
      r_ptr <= w_nxt;
  end
`else
  wire w_unused = clk ^ reset;

  always_comb begin
    o_gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_en && i_req[k]) begin
        o_gnt    = '0;
        o_gnt[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the rf16 write port among NREQ writeback requesters.
// Build option: RF_WB_RR_EN selects round-robin arbitration (see rr_arbiter).
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input logic              clk,
  input logic              reset,
  rf_wb_arbiter_if.slave   bus
);

  logic          r_wb_valid;
  logic [AW-1:0] r_wb_waddr;
  logic [DW-1:0] r_wb_wdata;

  logic            w_can_acc;
  logic            w_en;
  logic            w_acc;
  logic [NREQ-1:0] w_gnt;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            w_h0;
  logic            w_h1;

  // Empty, or the held entry drains this cycle
  assign w_can_acc = !r_wb_valid || !bus.rf_busy;
  assign w_en      = w_can_acc && !reset;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (bus.req_valid),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  assign bus.req_ready = w_gnt;
  assign w_acc         = |w_gnt;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = bus.req_waddr[i*AW +: AW];
        w_data = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
    end else if (w_acc) begin
      r_wb_valid <= 1'b1;
      r_wb_waddr <= w_addr;
      r_wb_wdata <= w_data;
    end else if (!bus.rf_busy) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.rf_wea   = r_wb_valid && !bus.rf_busy;
  assign bus.rf_waddr = r_wb_waddr;
  assign bus.rf_wdata = r_wb_wdata;

  always_comb begin
    w_h0 = r_wb_valid && (bus.r0addr == r_wb_waddr);
    w_h1 = r_wb_valid && (bus.r1addr == r_wb_waddr);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.r0addr == bus.req_waddr[i*AW +: AW])
        w_h0 = 1'b1;
      if (bus.req_valid[i] && bus.r1addr == bus.req_waddr[i*AW +: AW])
        w_h1 = 1'b1;
    end
  end

  assign bus.r0_hazard = w_h0 && !reset;
  assign bus.r1_hazard = w_h1 && !reset;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter.
// Works for both arbitration builds (RF_WB_RR_EN defined or not).
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    bus.req_waddr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.req_waddr = '0;
    bus.req_wdata = '0;
    put(0, 4'd9, 32'h1111_0000);
    put(1, 4'd12, 32'h2222_0000);
    put(2, 4'd4, 32'h3333_0000);
    put(3, 4'd0, 32'h4444_0000);
    bus.rf_busy = 1'b0;
    bus.r0addr  = 4'd9;
    bus.r1addr  = 4'd0;

    // 1: outputs quiet during reset
    #2;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_wea", 32'(bus.rf_wea), 32'h0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("rst_wdata", bus.rf_wdata, 32'h0);
    chk("rst_h0", 32'(bus.r0_hazard), 32'h0);
    chk("rst_h1", 32'(bus.r1_hazard), 32'h0);
    tick();
    tick();
    chk("rst_ready_clk", 32'(bus.req_ready), 32'h0);
    chk("rst_wea_clk", 32'(bus.rf_wea), 32'h0);

    tick();
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.r0addr    = 4'd14;
    bus.r1addr    = 4'd13;
    #1;

`ifdef RF_WB_RR_EN
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 32'(bus.req_ready),
          32'(1 << (k % 4)));
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
`endif

    // 2: single request, one-cycle latency
    tick();
    put(0, 4'd9, 32'h9999EEEE);
    bus.req_valid = 4'b0001;
    #1;
    chk("t2_ready", 32'(bus.req_ready), 32'h1);
    chk("t2_wea_pre", 32'(bus.rf_wea), 32'h0);
    tick();
    bus.req_valid = '0;
    #1;
    chk("t2_wea", 32'(bus.rf_wea), 32'h1);
    chk("t2_waddr", 32'(bus.rf_waddr), 32'd9);
    chk("t2_wdata", bus.rf_wdata, 32'h9999EEEE);
    tick();
    #1;
    chk("t2_drain", 32'(bus.rf_wea), 32'h0);

    // 3: two contenders, req1 before req2
    put(1, 4'd12, 32'hFFFFEEEE);
    put(2, 4'd4, 32'hABCDABCD);
    bus.req_valid = 4'b0110;
    #1;
    chk("t3_gnt_a", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0100;
    #1;
    chk("t3_wea_a", 32'(bus.rf_wea), 32'h1);
    chk("t3_waddr_a", 32'(bus.rf_waddr), 32'd12);
    chk("t3_wdata_a", bus.rf_wdata, 32'hFFFFEEEE);
    chk("t3_gnt_b", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    #1;
    chk("t3_wea_b", 32'(bus.rf_wea), 32'h1);
    chk("t3_waddr_b", 32'(bus.rf_waddr), 32'd4);
    chk("t3_wdata_b", bus.rf_wdata, 32'hABCDABCD);
    tick();

    // 4: rf_busy holds the entry and blocks grants
    put(0, 4'd5, 32'hABCDABCD);
    bus.req_valid = 4'b0001;
    #1;
    chk("t4_ready", 32'(bus.req_ready), 32'h1);
    tick();
    put(1, 4'd7, 32'h7777_0001);
    bus.req_valid = 4'b0010;
    bus.rf_busy   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_busy_wea%0d", k), 32'(bus.rf_wea), 32'h0);
      chk($sformatf("t4_busy_rdy%0d", k), 32'(bus.req_ready), 32'h0);
      chk($sformatf("t4_busy_addr%0d", k), 32'(bus.rf_waddr), 32'd5);
      tick();
    end
    bus.rf_busy = 1'b0;
    #1;
    chk("t4_wea", 32'(bus.rf_wea), 32'h1);
    chk("t4_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("t4_wdata", bus.rf_wdata, 32'hABCDABCD);
    chk("t4_ready_drain", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    #1;
    chk("t4_next_wea", 32'(bus.rf_wea), 32'h1);
    chk("t4_next_waddr", 32'(bus.rf_waddr), 32'd7);
    tick();

    // 5: hazards from held entry and pending requests
    put(0, 4'd9, 32'h11112222);
    bus.req_valid = 4'b0001;
    #1;
    tick();
    bus.req_valid = '0;
    bus.rf_busy   = 1'b1;
    bus.r0addr    = 4'd9;
    bus.r1addr    = 4'd0;
    #1;
    chk("t5_h0", 32'(bus.r0_hazard), 32'h1);
    chk("t5_h1", 32'(bus.r1_hazard), 32'h0);
    bus.req_valid = 4'b1000;
    #1;
    chk("t5_h1_req", 32'(bus.r1_hazard), 32'h1);
    chk("t5_h0_req", 32'(bus.r0_hazard), 32'h1);
    chk("t5_ready", 32'(bus.req_ready), 32'h0);
    tick();
    bus.req_valid = '0;
    bus.rf_busy   = 1'b0;
    #1;
    chk("t5_wea", 32'(bus.rf_wea), 32'h1);
    chk("t5_waddr", 32'(bus.rf_waddr), 32'd9);
    bus.r0addr = 4'd14;
    bus.r1addr = 4'd13;
    tick();
    #1;
    chk("t5_idle_wea", 32'(bus.rf_wea), 32'h0);
    chk("t5_idle_h0", 32'(bus.r0_hazard), 32'h0);

    // 6: async reset drops a pending write
    put(0, 4'd9, 32'h88887777);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    #1;
    chk("t6_wea", 32'(bus.rf_wea), 32'h1);
    chk("t6_waddr", 32'(bus.rf_waddr), 32'd9);
    chk("t6_wdata", bus.rf_wdata, 32'h88887777);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_wea", 32'(bus.rf_wea), 32'h0);
    chk("t6_rst_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("t6_rst_wdata", bus.rf_wdata, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_post_wea%0d", k), 32'(bus.rf_wea), 32'h0);
      chk($sformatf("t6_post_addr%0d", k), 32'(bus.rf_waddr), 32'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
